// File: rtl/overlap_accum_if.sv
// Term/result handshake bundle for overlap_accum: upstream term stream (s_*) and
// downstream frame result stream (m_*).
interface overlap_accum_if #(
  parameter int unsigned W  = 11,
  parameter int unsigned CW = 4
);
  logic           s_valid;
  logic           s_ready;
  logic [W-1:0]   s_in1;
  logic [W-1:0]   s_in2;
  logic [W-1:0]   s_in3;
  logic [W-1:0]   s_in4;
  logic           s_last;
  logic           m_valid;
  logic           m_ready;
  logic [2*W:0]   m_data;
  logic [CW-1:0]  m_terms;
  logic           m_ovf;

  // The accumulator consumes terms and produces results.
  modport slave (
    input  s_valid, s_in1, s_in2, s_in3, s_in4, s_last, m_ready,
    output s_ready, m_valid, m_data, m_terms, m_ovf
  );

  modport master (
    output s_valid, s_in1, s_in2, s_in3, s_in4, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_terms, m_ovf
  );
endinterface

// File: rtl/overlap_accum.sv
// Karatsuba overlap combiner: interleaves four partial products per term into a
// 2W+1 bit word and XOR-accumulates terms per frame, with overflow tracking.
module overlap_accum #(
  parameter int unsigned W         = 11,
  parameter int unsigned MAX_TERMS = 8,
  parameter int unsigned CW        = $clog2(MAX_TERMS + 1)
) (
  input logic            clk,
  input logic            rst_n,
  overlap_accum_if.slave bus
);

  localparam int unsigned DW = 2 * W + 1;
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_TERMS);

  typedef enum logic {StEmpty, StAccum} state_e;

  state_e          state_q, state_d;
  logic            s1_valid_q, s1_valid_d;
  logic            s1_last_q, s1_last_d;
  logic [DW-1:0]   s1_c_q, s1_c_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            m_valid_q, m_valid_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic [CW-1:0]   m_terms_q, m_terms_d;
  logic            m_ovf_q, m_ovf_d;

  logic [DW-1:0]   comb;
  logic            s1_adv, s_ready, s_acc, cnt_sat;
  logic [CW-1:0]   cnt_inc;

  // Even bits carry in1 and in4 shifted up one position; odd bits carry in2 ^ in3.
  always_comb begin
    comb = '0;
    for (int k = 0; k < W; k++) begin
      comb[2*k]   = bus.s_in1[k];
      comb[2*k+1] = bus.s_in2[k] ^ bus.s_in3[k];
    end
    for (int k = 1; k <= W; k++) begin
      comb[2*k] = comb[2*k] ^ bus.s_in4[k-1];
    end
  end

  always_comb begin
    // A last term stalls in S1 only while an unaccepted result occupies the output.
    s1_adv  = s1_valid_q && !(s1_last_q && m_valid_q && !bus.m_ready);
    s_ready = !s1_valid_q || s1_adv;
    s_acc   = bus.s_valid && s_ready;
    cnt_sat = (cnt_q == MaxCnt);
    cnt_inc = cnt_sat ? cnt_q : cnt_q + CW'(1);

    s1_valid_d = s_acc ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
    s1_c_d     = s_acc ? comb : s1_c_q;
    s1_last_d  = s_acc ? bus.s_last : s1_last_q;

    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    m_valid_d = m_valid_q && !bus.m_ready;
    m_data_d  = m_data_q;
    m_terms_d = m_terms_q;
    m_ovf_d   = m_ovf_q;

    if (s1_adv) begin
      if (s1_last_q) begin
        m_data_d  = acc_q ^ s1_c_q;
        m_terms_d = cnt_inc;
        m_ovf_d   = ovf_q | cnt_sat;
        m_valid_d = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
        ovf_d     = 1'b0;
        state_d   = StEmpty;
      end else begin
        acc_d   = acc_q ^ s1_c_q;
        cnt_d   = cnt_inc;
        ovf_d   = ovf_q | cnt_sat;
        state_d = StAccum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_c_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_terms_q  <= '0;
      m_ovf_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_c_q     <= s1_c_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_terms_q  <= m_terms_d;
      m_ovf_q    <= m_ovf_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_terms = m_terms_q;
  assign bus.m_ovf   = m_ovf_q;

endmodule

// File: doc/overlap_accum.md
OVERLAP_ACCUM -- requirements
Module: overlap_accum

Interface
REQ-001 Parameter W, default 11; width of each Karatsuba partial-product input (W >= 2).
REQ-002 Parameter MAX_TERMS, default 8; maximum terms per frame before overflow is flagged (>= 1).
REQ-003 Parameter CW, default $clog2(MAX_TERMS+1); width of the term counter.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port s_valid  input  1  input term valid.
REQ-007 Port s_ready  output  1  block can accept a term this cycle.
REQ-008 Port s_in1, s_in2, s_in3, s_in4  input  W each  four partial products of one term.
REQ-009 Port s_last  input  1  term is the final one of its frame.
REQ-010 Port m_valid  output  1  frame result valid.
REQ-011 Port m_ready  input  1  downstream accepts the result.
REQ-012 Port m_data  output  2W+1  accumulated overlap-combined result.
REQ-013 Port m_terms  output  CW  number of terms in the frame, saturating at MAX_TERMS.
REQ-014 Port m_ovf  output  1  frame contained more than MAX_TERMS terms.

Function
REQ-015 Per term, the combine C shall be: even bit 2k = s_in1[k] ^ s_in4[k-1], with s_in1 absent for k = W and s_in4 absent for k = 0, for k = 0..W; odd bit 2k+1 = s_in2[k] ^ s_in3[k], for k = 0..W-1.
REQ-016 Stage 1 (S1) shall register C, s_last and a valid bit on each accepted term (s_valid && s_ready).
REQ-017 Stage 2 shall hold accumulator ACC (2W+1 bits), term count CNT and an overflow sticky OVF; it consumes the S1 term in the cycle S1 advances.
REQ-018 Non-last S1 term: ACC <= ACC ^ C; CNT <= min(CNT+1, MAX_TERMS); OVF set if CNT already equals MAX_TERMS.
REQ-019 Last S1 term: output register <= {ACC ^ C, updated CNT, updated OVF}; m_valid <= 1; ACC, CNT, OVF cleared in the same cycle.
REQ-020 S1 advances unless it holds a last term while m_valid = 1 and m_ready = 0; a non-last S1 term always advances.
REQ-021 s_ready = !S1.valid || S1-advances-this-cycle; this permits one accepted term per cycle at full throughput.
REQ-022 m_valid shall clear on m_valid && m_ready unless a new result loads in the same cycle; in that case the new result replaces the old one and m_valid stays 1.
REQ-023 m_data, m_terms and m_ovf shall remain stable while m_valid = 1 and m_ready = 0.
REQ-024 Latency: a last term accepted in cycle t gives m_valid = 1 in cycle t+2 when the output register is free.
REQ-025 Frame FSM: EMPTY (CNT = 0) -> ACCUM on a non-last term; ACCUM or EMPTY -> EMPTY on a last term. A single-term frame (s_last on its first term) yields m_terms = 1.
REQ-026 Once a frame exceeds MAX_TERMS, accumulation shall continue; m_terms = MAX_TERMS and m_ovf = 1 for that frame only.
REQ-027 s_in*, s_last values are don't-care when s_valid = 0; a term is never lost or duplicated under any m_ready pattern.

Reset
REQ-028 When rst_n is low: S1.valid, ACC, CNT, OVF, m_valid, m_data, m_terms and m_ovf shall all be 0; s_ready = 1 from the first cycle after release.
REQ-029 Reset asserted mid-frame or with m_valid pending shall discard the partial frame and the pending result with no output.

Verification
REQ-030 W=11, one term in1=0x7FF, others 0, last=1 -> m_data=0x155555, m_terms=1, m_ovf=0, two cycles after accept.
REQ-031 W=11, term A in1=0x7FF (last=0), then term B in4=0x7FF (last=1) -> m_data=0x400001, m_terms=2.
REQ-032 W=11, one term in2=0x7FF, in3=0 -> m_data=0x2AAAAA; one term in2=in3=0x7FF -> m_data=0, m_terms=1.
REQ-033 MAX_TERMS=8, frame of 10 terms, each in1=0x001 -> m_data=0x000000 (even count), m_terms=8, m_ovf=1; the next 1-term frame gives m_ovf=0.
REQ-034 Back-to-back 1-term frames with m_ready held 0 for 5 cycles -> first result stable; s_ready drops once S1 holds a last term; after m_ready=1, all results delivered in order.
REQ-035 rst_n pulsed low after 3 terms of a frame -> no m_valid; a following 1-term frame in1=0x001 gives m_data=0x000001, m_terms=1.
